// File: rtl/serdesphy_supply_mon_if.sv
// Supply monitor signal bundle: raw comparator inputs and CSR controls
// towards the monitor, qualified levels and brown-out status back out.
interface serdesphy_supply_mon_if #(
  parameter int CNT_W = 8
);
  logic             dvdd_raw;
  logic             avdd_raw;
  logic             mon_en;
  logic             bo_clr;
  logic             dvdd_ok;
  logic             avdd_ok;
  logic             supplies_ok;
  logic             brownout_flag;
  logic [CNT_W-1:0] brownout_cnt;

  modport master (
    output dvdd_raw, avdd_raw, mon_en, bo_clr,
    input  dvdd_ok, avdd_ok, supplies_ok, brownout_flag, brownout_cnt
  );

  modport slave (
    input  dvdd_raw, avdd_raw, mon_en, bo_clr,
    output dvdd_ok, avdd_ok, supplies_ok, brownout_flag, brownout_cnt
  );
endinterface

// File: rtl/serdesphy_supply_mon.sv
// Supply qualification front-end for the SerDes PHY POR controller.
// Each rail is synchronised and debounced with separate assert/deassert
// windows; loss of a qualified rail is counted for CSR readback.

// One rail: 2-flop synchroniser plus OFF/QUAL_UP/ON/QUAL_DN debounce FSM.
module serdesphy_supply_mon_rail #(
  parameter int ASSERT_CYCLES   = 256,
  parameter int DEASSERT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n_in,
  input  logic raw,
  input  logic mon_en,
  output logic ok,
  output logic ok_nxt,
  output logic loss
);
  typedef enum logic [1:0] {OFF, QUAL_UP, ON, QUAL_DN} st_t;

  logic [1:0]  sync;
  logic        s;
  st_t         st, st_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [16:0] cnt_inc;

  assign s       = sync[1];
  assign cnt_inc = {1'b0, cnt} + 17'd1;

  // Synchroniser keeps running regardless of mon_en so a re-enable sees
  // the current rail level immediately.
  always_ff @(posedge clk) begin
    if (!rst_n_in) sync <= '0;
    else           sync <= {sync[0], raw};
  end

  // FSM state, run counter and registered ok level.
  always_ff @(posedge clk) begin
    if (!rst_n_in) begin
      st  <= OFF;
      cnt <= '0;
      ok  <= 1'b0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
      ok  <= ok_nxt;
    end
  end

  // Next-state / run-count / rail-loss decode. Disable wins silently.
  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    loss    = 1'b0;
    if (!mon_en) begin
      st_nxt  = OFF;
      cnt_nxt = '0;
    end else begin
      case (st)
        OFF: begin
          if (s && ASSERT_CYCLES == 1) begin
            st_nxt  = ON;
            cnt_nxt = '0;
          end else if (s) begin
            st_nxt  = QUAL_UP;
            cnt_nxt = 16'd1;
          end
        end
        QUAL_UP: begin
          if (!s) begin
            st_nxt  = OFF;
            cnt_nxt = '0;
          end else if (cnt_inc == 17'(ASSERT_CYCLES)) begin
            st_nxt  = ON;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt_inc[15:0];
          end
        end
        ON: begin
          if (!s && DEASSERT_CYCLES == 1) begin
            st_nxt  = OFF;
            cnt_nxt = '0;
            loss    = 1'b1;
          end else if (!s) begin
            st_nxt  = QUAL_DN;
            cnt_nxt = 16'd1;
          end
        end
        QUAL_DN: begin
          if (s) begin
            st_nxt  = ON;
            cnt_nxt = '0;
          end else if (cnt_inc == 17'(DEASSERT_CYCLES)) begin
            st_nxt  = OFF;
            cnt_nxt = '0;
            loss    = 1'b1;
          end else begin
            cnt_nxt = cnt_inc[15:0];
          end
        end
        default: begin
          st_nxt  = OFF;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  assign ok_nxt = (st_nxt == ON) || (st_nxt == QUAL_DN);
endmodule

module serdesphy_supply_mon #(
  parameter int ASSERT_CYCLES   = 256,
  parameter int DEASSERT_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                    clk,
  input  logic                    rst_n_in,
  serdesphy_supply_mon_if.slave   bus
);
  localparam int NUM_RAILS = 2;
  localparam int SUM_W     = CNT_W + 2;

  // Rail 0 is the 1.8 V digital supply, rail 1 the 3.3 V analog supply.
  logic [NUM_RAILS-1:0] raw, ok, ok_nxt, loss;
  logic [1:0]           inc;
  logic [CNT_W-1:0]     bo_cnt, bo_cnt_nxt, bo_base;
  logic [SUM_W-1:0]     bo_sum;
  logic                 bo_flag, sok;

  assign raw = {bus.avdd_raw, bus.dvdd_raw};

  serdesphy_supply_mon_rail #(
    .ASSERT_CYCLES  (ASSERT_CYCLES),
    .DEASSERT_CYCLES(DEASSERT_CYCLES)
  ) u_rail [NUM_RAILS-1:0] (
    .clk     (clk),
    .rst_n_in(rst_n_in),
    .raw     (raw),
    .mon_en  (bus.mon_en),
    .ok      (ok),
    .ok_nxt  (ok_nxt),
    .loss    (loss)
  );

  // A clear restarts the count from zero but still takes this edge's
  // events, so a loss coinciding with bo_clr is never dropped.
  assign inc        = {1'b0, loss[0]} + {1'b0, loss[1]};
  assign bo_base    = bus.bo_clr ? '0 : bo_cnt;
  assign bo_sum     = SUM_W'(bo_base) + SUM_W'(inc);
  assign bo_cnt_nxt = (bo_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                      : bo_sum[CNT_W-1:0];

  // Brown-out status and combined supply level.
  always_ff @(posedge clk) begin
    if (!rst_n_in) begin
      bo_cnt  <= '0;
      bo_flag <= 1'b0;
      sok     <= 1'b0;
    end else begin
      bo_cnt  <= bo_cnt_nxt;
      bo_flag <= (bo_flag & ~bus.bo_clr) | (inc != 2'd0);
      sok     <= &ok_nxt;
    end
  end

  assign bus.dvdd_ok       = ok[0];
  assign bus.avdd_ok       = ok[1];
  assign bus.supplies_ok   = sok;
  assign bus.brownout_flag = bo_flag;
  assign bus.brownout_cnt  = bo_cnt;
endmodule

// File: tb/tb_serdesphy_supply_mon.sv
// Directed bench: table of {inputs, cycles, expected outputs} for the
// default-parameter monitor, plus a saturation sequence on a CNT_W=2 copy.
module tb_serdesphy_supply_mon;
  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serdesphy_supply_mon_if #(.CNT_W(8)) bus0 ();
  serdesphy_supply_mon_if #(.CNT_W(2)) bus1 ();

  serdesphy_supply_mon #(.ASSERT_CYCLES(256), .DEASSERT_CYCLES(4), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n_in(rst0), .bus(bus0.slave));

  serdesphy_supply_mon #(.ASSERT_CYCLES(4), .DEASSERT_CYCLES(2), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n_in(rst1), .bus(bus1.slave));

  typedef struct {
    logic       rst_n, en, clr, d, a;
    int         n;
    logic       ed, ea, es, ef;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst_n, logic en, logic clr, logic d, logic a, int n,
                              logic ed, logic ea, logic es, logic ef, logic [7:0] ec);
    vec_t v;
    v.rst_n = rst_n; v.en = en; v.clr = clr; v.d = d; v.a = a; v.n = n;
    v.ed = ed; v.ea = ea; v.es = es; v.ef = ef; v.ec = ec;
    return v;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk0(string tag, logic ed, logic ea, logic es, logic ef, logic [7:0] ec);
    chk({tag, " dvdd_ok"},     8'(bus0.dvdd_ok),       8'(ed));
    chk({tag, " avdd_ok"},     8'(bus0.avdd_ok),       8'(ea));
    chk({tag, " supplies_ok"}, 8'(bus0.supplies_ok),   8'(es));
    chk({tag, " bo_flag"},     8'(bus0.brownout_flag), 8'(ef));
    chk({tag, " bo_cnt"},      bus0.brownout_cnt,      ec);
  endtask

  initial begin
    // rst, en, clr, d, a, cycles | dvdd_ok avdd_ok sup_ok flag cnt
    tbl.push_back(mk(1,1,0,0,0,  5, 0,0,0,0,0)); // idle, rails low
    tbl.push_back(mk(1,1,0,1,1,257, 0,0,0,0,0)); // power-up: not yet at edge 256
    tbl.push_back(mk(1,1,0,1,1,  1, 1,1,1,0,0)); // qualified after edge 257
    tbl.push_back(mk(1,1,0,0,1,  3, 1,1,1,0,0)); // 3-cycle dvdd glitch
    tbl.push_back(mk(1,1,0,1,1, 10, 1,1,1,0,0)); // glitch filtered
    tbl.push_back(mk(1,1,0,0,1,  5, 1,1,1,0,0)); // long low: edges 0..4
    tbl.push_back(mk(1,1,0,0,1,  1, 0,1,0,1,1)); // lost at edge 5
    tbl.push_back(mk(1,1,0,0,1,  4, 0,1,0,1,1)); // rest of 10-cycle low
    tbl.push_back(mk(1,1,0,1,1,257, 0,1,0,1,1)); // requalifying
    tbl.push_back(mk(1,1,0,1,1,  1, 1,1,1,1,1));
    tbl.push_back(mk(1,1,0,0,0,  5, 1,1,1,1,1)); // dual drop, before loss
    tbl.push_back(mk(1,1,0,0,0,  1, 0,0,0,1,3)); // inc=2 on one edge
    tbl.push_back(mk(1,1,0,1,1,257, 0,0,0,1,3));
    tbl.push_back(mk(1,1,0,1,1,  1, 1,1,1,1,3));
    tbl.push_back(mk(1,1,0,1,0,  5, 1,1,1,1,3)); // avdd drop, before loss
    tbl.push_back(mk(1,1,1,1,0,  1, 1,0,0,1,1)); // clear collides with loss
    tbl.push_back(mk(1,1,0,1,0,  2, 1,0,0,1,1));
    tbl.push_back(mk(1,1,1,1,0,  1, 1,0,0,0,0)); // plain clear
    tbl.push_back(mk(1,1,0,1,1,200, 1,0,0,0,0)); // avdd high 200
    tbl.push_back(mk(1,1,0,1,0,  1, 1,0,0,0,0)); // one low cycle
    tbl.push_back(mk(1,1,0,1,1,257, 1,0,0,0,0)); // restart: not early
    tbl.push_back(mk(1,1,0,1,1,  1, 1,1,1,0,0));
    tbl.push_back(mk(1,0,0,1,1,  1, 0,0,0,0,0)); // mon_en off: ok drops, no event
    tbl.push_back(mk(1,0,0,0,0, 10, 0,0,0,0,0)); // loss while disabled not counted
    tbl.push_back(mk(1,0,0,1,1, 10, 0,0,0,0,0));
    tbl.push_back(mk(1,1,0,1,1,255, 0,0,0,0,0)); // re-enable, s already high
    tbl.push_back(mk(1,1,0,1,1,  1, 1,1,1,0,0));
    tbl.push_back(mk(1,1,0,0,0,  6, 0,0,0,1,2)); // dual loss again
    tbl.push_back(mk(1,1,0,1,1,100, 0,0,0,1,2)); // mid-qualification
    tbl.push_back(mk(0,1,0,1,1,  1, 0,0,0,0,0)); // reset clears everything
    tbl.push_back(mk(1,1,0,1,1,257, 0,0,0,0,0)); // restart from OFF
    tbl.push_back(mk(1,1,0,1,1,  1, 1,1,1,0,0));

    bus0.dvdd_raw = 1'b0; bus0.avdd_raw = 1'b0; bus0.mon_en = 1'b0; bus0.bo_clr = 1'b0;
    bus1.dvdd_raw = 1'b0; bus1.avdd_raw = 1'b0; bus1.mon_en = 1'b0; bus1.bo_clr = 1'b0;

    // Reset state of the main instance.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk0("reset", 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      rst0          = tbl[i].rst_n;
      bus0.mon_en   = tbl[i].en;
      bus0.bo_clr   = tbl[i].clr;
      bus0.dvdd_raw = tbl[i].d;
      bus0.avdd_raw = tbl[i].a;
      repeat (tbl[i].n) @(posedge clk);
      @(negedge clk);
      chk0($sformatf("vec%0d", i), tbl[i].ed, tbl[i].ea, tbl[i].es, tbl[i].ef, tbl[i].ec);
    end
    rst0 = 1'b0;

    // Saturation on a 2-bit counter: five dvdd loss events hold at 3.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("sat reset cnt", 8'(bus1.brownout_cnt), 8'd0);
    rst1 = 1'b1;
    bus1.mon_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus1.dvdd_raw = 1'b1;
      repeat (7) @(posedge clk);
      @(negedge clk);
      chk($sformatf("sat%0d ok up", k), 8'(bus1.dvdd_ok), 8'd1);
      bus1.dvdd_raw = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk($sformatf("sat%0d ok down", k), 8'(bus1.dvdd_ok), 8'd0);
      chk($sformatf("sat%0d flag", k), 8'(bus1.brownout_flag), 8'd1);
      chk($sformatf("sat%0d cnt", k), 8'(bus1.brownout_cnt), (k + 1 > 3) ? 8'd3 : 8'(k + 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
